// File: rtl/in_wrapper.sv
// Input-side bus wrapper for the FP unit: collects operands A then B over a
// 4-phase inReady/inAccepted handshake, starts the core and waits for doneFP.
//
// state  | meaning
// WAIT_A | idle, waiting for host request carrying operand A
// ACK_A  | A captured, acknowledging until host drops inReady
// WAIT_B | waiting for host request carrying operand B
// ACK_B  | B captured, acknowledging until host drops inReady
// START  | one-cycle start pulse to the FP core
// RUN    | core owns the operands until doneFP
module in_wrapper #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inBus,
  input  logic             inReady,
  input  logic             doneFP,
  output logic             inAccepted,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic             startFP,
  output logic             busy
);

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    ACK_A  = 3'd1,
    WAIT_B = 3'd2,
    ACK_B  = 3'd3,
    START  = 3'd4,
    RUN    = 3'd5
  } state_t;

  state_t state, state_next;
  logic   cap_a, cap_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_A;
    else     state <= state_next;
  end

  // Operands are written only on the edge that leaves the matching WAIT state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA <= '0;
      opB <= '0;
    end else begin
      if (cap_a) opA <= inBus;
      if (cap_b) opB <= inBus;
    end
  end

  always_comb begin
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    inAccepted = 1'b0;
    startFP    = 1'b0;
    busy       = 1'b0;
    case (state)
      WAIT_A: begin
        if (inReady) begin
          cap_a      = 1'b1;
          state_next = ACK_A;
        end
      end
      ACK_A: begin
        inAccepted = 1'b1;
        if (!inReady) state_next = WAIT_B;
      end
      WAIT_B: begin
        if (inReady) begin
          cap_b      = 1'b1;
          state_next = ACK_B;
        end
      end
      ACK_B: begin
        inAccepted = 1'b1;
        if (!inReady) state_next = START;
      end
      START: begin
        startFP    = 1'b1;
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (doneFP) state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase
  end

endmodule
